// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline controller.
// Handles memory-wait, redirect and load-use stalls, and keeps the performance counters.
module pipe_ctrl #(
    parameter int NSTAGES = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_resp,
    input  logic               dmem_req,
    input  logic               dmem_resp,
    input  logic               hazard,
    input  logic               redirect,
    output logic               pc_load,
    output logic [NSTAGES-2:0] stage_load,
    output logic [NSTAGES-2:0] stage_valid,
    output logic               mem_en,
    output logic               wb_en,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   retired
);

    localparam int R = NSTAGES - 1;

    logic [R-1:0]     valid_q;
    logic [R-1:0]     valid_nxt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] retired_q;
    logic             mem_wait;
    logic             take_redirect;
    logic             take_hazard;

    assign stage_valid  = valid_q;
    assign stall_cycles = stall_q;
    assign retired      = retired_q;

    // Per-cycle decision: memory wait beats redirect, which beats the hazard bubble.
    always_comb begin
        mem_en        = !rst && valid_q[NSTAGES-3];
        mem_wait      = !imem_resp || (dmem_req && mem_en && !dmem_resp);
        take_redirect = !mem_wait && redirect && valid_q[1];
        take_hazard   = !mem_wait && !take_redirect && hazard && valid_q[0];
        pc_load       = !rst && !mem_wait && !take_hazard;
        wb_en         = !rst && valid_q[R-1] && !mem_wait;
        stage_load    = '1;
        if (rst || mem_wait) begin
            stage_load = '0;
        end else if (take_hazard) begin
            stage_load = {{(R-1){1'b1}}, 1'b0};
        end
    end

    // Next valid vector: shift forward, squashing IF/ID on redirect or bubbling ID on hazard.
    always_comb begin
        valid_nxt = valid_q;
        if (!mem_wait) begin
            if (take_redirect) begin
                valid_nxt = {valid_q[R-2:1], 2'b00};
            end else if (take_hazard) begin
                valid_nxt = {valid_q[R-2:1], 1'b0, valid_q[0]};
            end else begin
                valid_nxt = {valid_q[R-2:0], 1'b1};
            end
        end
    end

    // Valid bits and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            stall_q   <= '0;
            retired_q <= '0;
        end else begin
            valid_q <= valid_nxt;
            if (mem_wait || take_hazard) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (!mem_wait && valid_q[R-1]) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against
// an occupancy-based model, plus a wide/narrow-counter second instance.
module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int R  = NS - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, imem_resp, dmem_req, dmem_resp, hazard, redirect;
    logic         pc_load, mem_en, wb_en;
    logic [R-1:0] stage_load, stage_valid;
    logic [31:0]  stall_cycles, retired;

    logic         rst2;
    logic         one = 1'b1;
    logic         zero = 1'b0;
    logic         pc_load2, mem_en2, wb_en2;
    logic [5:0]   stage_load2, stage_valid2;
    logic [3:0]   stall2, retired2;

    int n_checks = 0;
    int n_fail   = 0;

    bit [R-1:0] mv;
    bit [31:0]  mstall;
    bit [31:0]  mret;
    int         k2;
    bit         track2;

    pipe_ctrl #(.NSTAGES(NS), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .hazard(hazard), .redirect(redirect),
        .pc_load(pc_load), .stage_load(stage_load), .stage_valid(stage_valid),
        .mem_en(mem_en), .wb_en(wb_en), .stall_cycles(stall_cycles),
        .retired(retired)
    );

    pipe_ctrl #(.NSTAGES(7), .CNT_W(4)) dut7 (
        .clk(clk), .rst(rst2), .imem_resp(one), .dmem_req(zero),
        .dmem_resp(zero), .hazard(zero), .redirect(zero),
        .pc_load(pc_load2), .stage_load(stage_load2), .stage_valid(stage_valid2),
        .mem_en(mem_en2), .wb_en(wb_en2), .stall_cycles(stall2),
        .retired(retired2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare every output against the model, then advance it.
    task automatic drive(input bit r, input bit im, input bit dq,
                         input bit ds, input bit hz, input bit rd);
        bit         mw, rq, hq, e_pc, e_me, e_wb;
        bit [R-1:0] e_sl, nv, ones;
        int         e2;
        rst = r; imem_resp = im; dmem_req = dq;
        dmem_resp = ds; hazard = hz; redirect = rd;
        #1;
        ones = '1;
        if (r) begin
            mv = '0; mstall = 0; mret = 0;
        end
        mw = !im || (dq && mv[R-2] && !ds);
        rq = !mw && rd && mv[1];
        hq = !mw && !rq && hz && mv[0];
        if (r) begin
            e_pc = 0; e_sl = '0; e_me = 0; e_wb = 0;
        end else begin
            e_pc = !mw && !hq;
            e_sl = mw ? '0 : (hq ? (ones << 1) : ones);
            e_me = mv[R-2];
            e_wb = mv[R-1] && !mw;
        end
        chk("pc_load", 64'(pc_load), 64'(e_pc));
        chk("stage_load", 64'(stage_load), 64'(e_sl));
        chk("mem_en", 64'(mem_en), 64'(e_me));
        chk("wb_en", 64'(wb_en), 64'(e_wb));
        chk("stage_valid", 64'(stage_valid), 64'(mv));
        chk("stall_cycles", 64'(stall_cycles), 64'(mstall));
        chk("retired", 64'(retired), 64'(mret));
        if (!r) begin
            if (mw || hq) mstall++;
            if (!mw) begin
                if (mv[R-1]) mret++;
                nv = mv << 1;
                if (rq) begin
                    nv[1] = 0; nv[0] = 0;
                end else if (hq) begin
                    nv[1] = 0; nv[0] = mv[0];
                end else begin
                    nv[0] = 1;
                end
                mv = nv;
            end
        end
        if (track2 && k2 < 40) begin
            e2 = (k2 >= 6) ? 63 : ((1 << k2) - 1);
            chk("valid7", 64'(stage_valid2), 64'(e2));
            chk("retired7", 64'(retired2), 64'((k2 > 6) ? (k2 - 6) % 16 : 0));
            if (k2 == 5) chk("fill7_5", 64'(stage_valid2), 64'h1f);
            if (k2 == 6) chk("fill7_6", 64'(stage_valid2), 64'h3f);
            if (k2 == 21) chk("ret7_15", 64'(retired2), 64'd15);
            if (k2 == 22) chk("ret7_wrap", 64'(retired2), 64'd0);
            k2++;
        end
    endtask

    bit [3:0] fill_lit [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        rst = 1; rst2 = 1; track2 = 0; k2 = 0;
        imem_resp = 0; dmem_req = 0; dmem_resp = 0; hazard = 0; redirect = 0;
        @(negedge clk);
        @(negedge clk);
        drive(1, 1, 1, 0, 1, 1);
        chk("rst_pc_load", 64'(pc_load), 64'd0);
        @(negedge clk);

        rst2 = 0; track2 = 1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            @(negedge clk);
            if (i < 4) chk("fill", 64'(stage_valid), 64'(fill_lit[i]));
        end
        chk("retired_fill", 64'(retired), 64'd2);

        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            chk("dstall_pc", 64'(pc_load), 64'd0);
            chk("dstall_sl", 64'(stage_load), 64'd0);
            @(negedge clk);
        end
        chk("dstall_cnt", 64'(stall_cycles), 64'd3);
        chk("dstall_valid", 64'(stage_valid), 64'hf);
        drive(0, 1, 1, 1, 0, 0);
        @(negedge clk);

        drive(0, 1, 0, 0, 1, 0);
        chk("haz_pc", 64'(pc_load), 64'd0);
        chk("haz_sl", 64'(stage_load), 64'he);
        @(negedge clk);
        chk("haz_valid", 64'(stage_valid), 64'hd);
        chk("haz_cnt", 64'(stall_cycles), 64'd4);

        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            @(negedge clk);
        end
        chk("refill", 64'(stage_valid), 64'hf);

        drive(0, 1, 0, 0, 1, 1);
        chk("rdhz_pc", 64'(pc_load), 64'd1);
        @(negedge clk);
        chk("rdhz_valid", 64'(stage_valid), 64'hc);
        chk("rdhz_cnt", 64'(stall_cycles), 64'd4);

        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            @(negedge clk);
        end
        chk("pre_rd", 64'(stage_valid), 64'h3);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            @(negedge clk);
        end
        chk("rd_held_valid", 64'(stage_valid), 64'h3);
        chk("rd_held_cnt", 64'(stall_cycles), 64'd6);
        drive(0, 1, 0, 0, 0, 1);
        @(negedge clk);
        chk("rd_once", 64'(stage_valid), 64'h4);

        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 1, 0, 0, 0);
        chk("bubble_mem_en", 64'(mem_en), 64'd0);
        chk("bubble_pc", 64'(pc_load), 64'd1);
        @(negedge clk);
        chk("bubble_cnt", 64'(stall_cycles), 64'd6);

        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 1);
        chk("midrst_valid", 64'(stage_valid), 64'd0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst", 64'(stage_valid), 64'h1);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 15));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
